// File: rtl/hcsr04_pkg.sv
// Shared HC-SR04 definitions: FSM states and 50 MHz timing defaults,
// used by both this responder and the sensor driver.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG_HI = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    localparam int DEF_MIN_TRIG_CYCLES   = 500;
    localparam int DEF_ECHO_DELAY_CYCLES = 25000;
    localparam int DEF_CYC_PER_MM        = 292;
    localparam int DEF_MAX_MM            = 4000;
    localparam int DEF_MIN_MM            = 20;
    localparam int DEF_TIMEOUT_CYCLES    = 1900000;
    localparam int DEF_HOLDOFF_CYCLES    = 500000;
    localparam int DEF_CNT_W             = 21;

    localparam int DIST_W = 12;
    localparam int MULT_W = 9;
    localparam int PROD_W = DIST_W + MULT_W;

endpackage

// File: rtl/hcsr04_echo_responder_sync_2ff.sv
// 1-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 sensor emulator: answers a trigger pulse with an echo pulse
// whose width encodes dist_mm, then holds off before re-arming.
module hcsr04_echo_responder
    import hcsr04_pkg::*;
#(
    parameter int MIN_TRIG_CYCLES   = DEF_MIN_TRIG_CYCLES,
    parameter int ECHO_DELAY_CYCLES = DEF_ECHO_DELAY_CYCLES,
    parameter int CYC_PER_MM        = DEF_CYC_PER_MM,
    parameter int MAX_MM            = DEF_MAX_MM,
    parameter int MIN_MM            = DEF_MIN_MM,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
    parameter int HOLDOFF_CYCLES    = DEF_HOLDOFF_CYCLES,
    parameter int CNT_W             = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [DIST_W-1:0] dist_mm,
    input  logic              obj_present,
    output logic              echo,
    output logic              busy,
    output logic              done,
    output logic              short_trig
);

    localparam logic [CNT_W-1:0] TRIG_MIN = CNT_W'(MIN_TRIG_CYCLES);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(ECHO_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_W    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [DIST_W-1:0] D_MIN   = DIST_W'(MIN_MM);
    localparam logic [DIST_W-1:0] D_MAX   = DIST_W'(MAX_MM);
    localparam logic [MULT_W-1:0] K_MM    = MULT_W'(CYC_PER_MM);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] width_n;
    logic [CNT_W-1:0] w_calc;
    logic [DIST_W-1:0] dist_eff;
    logic [PROD_W-1:0] prod;
    logic             trig_s;
    logic [1:0]       vld;
    logic             armed;
    logic             armed_n;
    logic             echo_n;
    logic             done_n;
    logic             short_n;

    sync_2ff u_trig_sync (
        .clk (clk),
        .rst (rst),
        .d   (trig),
        .q   (trig_s)
    );

    // trig_s is meaningless until the synchronizer has refilled after reset,
    // so arming waits for vld[1]; a level held through reset is never taken
    // as a fresh rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 2'b00;
        end else begin
            vld <= {vld[0], 1'b1};
        end
    end

    always_comb begin
        dist_eff = (dist_mm < D_MIN) ? D_MIN : dist_mm;
        prod     = {{MULT_W{1'b0}}, dist_eff} * {{DIST_W{1'b0}}, K_MM};
        if (!obj_present || (dist_mm > D_MAX)) begin
            w_calc = TMO_W;
        end else begin
            w_calc = CNT_W'(prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            width      <= '0;
            armed      <= 1'b0;
            echo       <= 1'b0;
            done       <= 1'b0;
            short_trig <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            width      <= width_n;
            armed      <= armed_n;
            echo       <= echo_n;
            done       <= done_n;
            short_trig <= short_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        width_n = width;
        armed_n = 1'b0;
        echo_n  = 1'b0;
        done_n  = 1'b0;
        short_n = 1'b0;
        unique case (state)
            IDLE: begin
                armed_n = vld[1] & ~trig_s;
                if (armed && trig_s) begin
                    state_n = TRIG_HI;
                    cnt_n   = '0;
                    armed_n = 1'b0;
                end
            end
            TRIG_HI: begin
                if (trig_s) begin
                    if (cnt < TRIG_MIN) begin
                        cnt_n = cnt + ONE;
                    end
                end else if (cnt >= TRIG_MIN) begin
                    width_n = w_calc;
                    cnt_n   = '0;
                    state_n = BURST;
                end else begin
                    short_n = 1'b1;
                    state_n = IDLE;
                end
            end
            BURST: begin
                if (cnt == DLY_LAST) begin
                    echo_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = ECHO;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            ECHO: begin
                if (cnt == width - ONE) begin
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = HOLDOFF;
                end else begin
                    echo_n = 1'b1;
                    cnt_n  = cnt + ONE;
                end
            end
            HOLDOFF: begin
                if (cnt == HLD_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hcsr04_echo_responder.sv
// Directed self-checking bench for hcsr04_echo_responder with scaled-down
// timing (MIN_TRIG 10, DELAY 20, 3 cyc/mm, 2..100 mm, TIMEOUT 1000, HOLDOFF 50).
module tb_hcsr04_echo_responder;

    localparam int LIM = 5000;

    logic        clk;
    logic        rst;
    logic        trig;
    logic [11:0] dist_mm;
    logic        obj_present;
    logic        echo;
    logic        busy;
    logic        done;
    logic        short_trig;

    int n_run;
    int n_fail;

    hcsr04_echo_responder #(
        .MIN_TRIG_CYCLES   (10),
        .ECHO_DELAY_CYCLES (20),
        .CYC_PER_MM        (3),
        .MAX_MM            (100),
        .MIN_MM            (2),
        .TIMEOUT_CYCLES    (1000),
        .HOLDOFF_CYCLES    (50),
        .CNT_W             (21)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig        (trig),
        .dist_mm     (dist_mm),
        .obj_present (obj_present),
        .echo        (echo),
        .busy        (busy),
        .done        (done),
        .short_trig  (short_trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_trig(input int n);
        @(negedge clk);
        trig = 1'b1;
        repeat (n) @(negedge clk);
        trig = 1'b0;
    endtask

    // Trigger, then measure delay to echo rise, echo width, done pulses and
    // holdoff length; optional dist change in BURST and retriggers later on.
    task automatic run_echo(input int n, input int chg, input int rt_e,
                            input int rt_h, output int dly, output int w,
                            output int dn, output int hold);
        pulse_trig(n);
        dly = 0;
        while (echo !== 1'b1 && dly < LIM) begin
            @(negedge clk);
            dly++;
            if (chg >= 0 && dly == 5) dist_mm = 12'(chg);
        end
        w = 0;
        while (echo === 1'b1 && w < LIM) begin
            w++;
            if (rt_e > 0 && w == rt_e) trig = 1'b1;
            if (rt_e > 0 && w == rt_e + 12) trig = 1'b0;
            @(negedge clk);
        end
        trig = 1'b0;
        dn = 0;
        hold = 0;
        while (busy === 1'b1 && hold < LIM) begin
            if (done === 1'b1) dn++;
            if (rt_h > 0 && hold == rt_h) trig = 1'b1;
            if (rt_h > 0 && hold == rt_h + 12) trig = 1'b0;
            @(negedge clk);
            hold++;
        end
        trig = 1'b0;
    endtask

    initial begin
        int dly, w, dn, hold, sc, eh, bh, k;
        n_run       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        trig        = 1'b0;
        dist_mm     = 12'd50;
        obj_present = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_echo", int'(echo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_short", int'(short_trig), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // nominal: 50 mm -> 150 cycles; trig drop to echo high is 2 sync + 1 detect + 20
        run_echo(12, -1, 0, 0, dly, w, dn, hold);
        check("nom_delay", dly, 23);
        check("nom_width", w, 150);
        check("nom_done", dn, 1);
        check("nom_holdoff", hold, 50);

        // short trigger rejected
        pulse_trig(5);
        sc = 0;
        eh = 0;
        repeat (30) begin
            @(negedge clk);
            if (short_trig === 1'b1) sc++;
            if (echo === 1'b1) eh++;
        end
        check("short_pulses", sc, 1);
        check("short_echo", eh, 0);
        check("short_busy", int'(busy), 0);

        // range limits
        dist_mm = 12'd101;
        run_echo(12, -1, 0, 0, dly, w, dn, hold);
        check("w_101mm", w, 1000);
        dist_mm = 12'd100;
        run_echo(12, -1, 0, 0, dly, w, dn, hold);
        check("w_100mm", w, 300);
        dist_mm = 12'd50;
        obj_present = 1'b0;
        run_echo(12, -1, 0, 0, dly, w, dn, hold);
        check("w_noobj", w, 1000);
        obj_present = 1'b1;
        dist_mm = 12'd0;
        run_echo(12, -1, 0, 0, dly, w, dn, hold);
        check("w_0mm", w, 6);
        dist_mm = 12'd2;
        run_echo(12, -1, 0, 0, dly, w, dn, hold);
        check("w_2mm", w, 6);
        dist_mm = 12'd7;
        run_echo(12, -1, 0, 0, dly, w, dn, hold);
        check("w_7mm", w, 21);

        // retriggers during ECHO and HOLDOFF are ignored
        dist_mm = 12'd50;
        run_echo(12, -1, 10, 10, dly, w, dn, hold);
        check("rt_width", w, 150);
        check("rt_holdoff", hold, 50);
        eh = 0;
        bh = 0;
        repeat (40) begin
            @(negedge clk);
            if (echo === 1'b1) eh++;
            if (busy === 1'b1) bh++;
        end
        check("rt_no_echo", eh, 0);
        check("rt_no_busy", bh, 0);
        run_echo(12, -1, 0, 0, dly, w, dn, hold);
        check("rt_second_width", w, 150);

        // width latched at the falling edge
        run_echo(12, 10, 0, 0, dly, w, dn, hold);
        check("latch_width", w, 150);
        dist_mm = 12'd50;

        // reset mid-ECHO with trig held high across it
        pulse_trig(12);
        k = 0;
        while (echo !== 1'b1 && k < LIM) begin
            @(negedge clk);
            k++;
        end
        check("rst_pre_delay", k, 23);
        repeat (30) @(negedge clk);
        trig = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_async_echo", int'(echo), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        eh = 0;
        bh = 0;
        repeat (40) begin
            @(negedge clk);
            if (echo === 1'b1) eh++;
            if (busy === 1'b1) bh++;
        end
        check("held_no_echo", eh, 0);
        check("held_no_busy", bh, 0);
        trig = 1'b0;
        run_echo(12, -1, 0, 0, dly, w, dn, hold);
        check("post_rst_delay", dly, 23);
        check("post_rst_width", w, 150);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/hcsr04_echo_responder.md
Name: hcsr04_echo_responder

Overview:
- Synthesizable responder for the HC-SR04 ultrasonic protocol: the sensor end, facing the AGV's trigger/echo measurement logic.
- Accepts a trigger pulse and returns an echo pulse whose width encodes a programmable distance in mm.
- Used for hardware-in-loop and simulation of obstacle detection, with no physical sensor on the board.
- Drives the same echo net the sensor driver samples, and listens on its trigger net.

Parameters:
- MIN_TRIG_CYCLES, 500, minimum trigger high time in clk cycles (10 us at 50 MHz).
- ECHO_DELAY_CYCLES, 25000, cycles from accepted trigger fall to echo rise (burst emulation, 500 us).
- CYC_PER_MM, 292, echo cycles per mm of distance (round trip at 343 m/s, 20 ns clk).
- MAX_MM, 4000, largest distance that still produces a distance echo.
- MIN_MM, 20, smaller distances are clamped to this value.
- TIMEOUT_CYCLES, 1900000, echo width when there is no object or the distance is out of range (38 ms).
- HOLDOFF_CYCLES, 500000, recovery time after echo falls before a new trigger is accepted.
- CNT_W, 21, width of the internal counters; must hold the largest of the cycle values above.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- trig  in  1  trigger from the sensor driver; asynchronous to clk.
- dist_mm  in  12  emulated object distance in mm.
- obj_present  in  1  1 = object in range, 0 = no echo return (timeout width).
- echo  out  1  echo pulse to the sensor driver.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the cycle echo falls.
- short_trig  out  1  one-cycle pulse when a trigger shorter than MIN_TRIG_CYCLES is rejected.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 0. Assertion mid-operation aborts immediately; echo drops asynchronously.
- trig passes through a 2-flop synchronizer to give trig_s. All timing below counts clk edges on trig_s.
- IDLE: on a trig_s rising edge, go to TRIG_HI and clear the counter.
- TRIG_HI: count cycles while trig_s = 1.
  - When trig_s falls with count >= MIN_TRIG_CYCLES: latch the echo width W, go to BURST.
  - When trig_s falls with count < MIN_TRIG_CYCLES: pulse short_trig, return to IDLE.
  - The count saturates at MIN_TRIG_CYCLES; a trigger held high indefinitely stays in TRIG_HI.
- Width rule, evaluated on the same cycle as the falling edge:
  - If obj_present = 0 or dist_mm > MAX_MM, then W = TIMEOUT_CYCLES.
  - Otherwise W = max(dist_mm, MIN_MM) * CYC_PER_MM.
  - Uses one unsigned multiply, 12 x 9 bits, truncated to CNT_W.
  - Later changes to dist_mm or obj_present have no effect on the current echo.
- BURST: wait. echo rises on exactly the ECHO_DELAY_CYCLES-th edge after the falling-edge detect edge; the state then becomes ECHO.
- ECHO: echo is high for exactly W clk cycles. On the edge it falls, done pulses and the state becomes HOLDOFF.
- HOLDOFF: wait HOLDOFF_CYCLES, then go to IDLE. trig activity here and in BURST/ECHO is ignored; no error is flagged.
- A trigger already high when IDLE is entered is not accepted. A fresh rising edge is required.
- echo is a registered output with no glitches. busy = (state != IDLE).

Decomposition:
- Shared package hcsr04_pkg:
  - state enum (IDLE, TRIG_HI, BURST, ECHO, HOLDOFF);
  - the timing defaults at 50 MHz, so the sensor driver and this block share the same values.
- One sub-module, sync_2ff (1-bit two-flop synchronizer with async reset), reused for echo on the driver side.

Test Plan:
Bench parameters: MIN_TRIG=10, ECHO_DELAY=20, CYC_PER_MM=3, MIN_MM=2, MAX_MM=100, TIMEOUT=1000, HOLDOFF=50.
1. Nominal: trig high 12 cycles with dist_mm=50 and obj_present=1 -> echo rises 20 cycles after trig_s falls, high exactly 150 cycles, done one cycle, busy clears 50 cycles later.
2. Short trigger: trig high 5 cycles -> short_trig pulses once, echo stays 0, busy returns 0.
3. Range limits: dist_mm=101 -> echo width 1000. obj_present=0 -> width 1000. dist_mm=0 -> width 6.
4. Retrigger: a new valid trig during ECHO and during HOLDOFF -> ignored, echo width unchanged. A valid trig after HOLDOFF -> a second echo with correct width.
5. Latching: dist_mm changed from 50 to 10 during BURST -> echo width still 150.
6. Reset: rst asserted mid-ECHO -> echo, busy and done go 0 at once. After release, trig held high until IDLE is not accepted until it falls and rises again.
